im_fetch_master: RTL and testbench
==================================

IM_FETCH_MASTER -- requirements
Module: im_fetch_master

Interface
REQ-001 The block SHALL take parameter data_size, default 32, as the instruction/data width.
REQ-002 The block SHALL take parameter addr_size, default 10, as the word-address width of IM_addr.
REQ-003 The block SHALL take parameter BOOT_PC, default 32'h0, as the byte PC loaded at reset.
REQ-004 The block SHALL take parameter TIMEOUT, default 15, as the maximum wait cycles for IM_finish.
REQ-005 The block SHALL have one clock; reset is synchronous and active-high.
REQ-006 Ports (name, direction, width, meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- IM_enable  out  1  memory request strobe
- IM_read  out  1  read request
- IM_write  out  1  write request, tied 0
- IM_in  out  data_size  write data, tied 0
- IM_addr  out  addr_size  word address = pc[addr_size+1:2]
- IM_out  in  data_size  read data
- IM_ready  in  1  memory idle (informational only)
- IM_resp  in  2  OKAY=00, ERROR=01, RETRY=10, SPLIT=11
- IM_finish  in  1  response valid this cycle
- redirect_valid  in  1  flush and restart at redirect_pc
- redirect_pc  in  32  new byte PC
- inst_ready  in  1  consumer pops head entry
- inst_valid  out  1  buffer non-empty
- inst_out  out  data_size  head instruction
- inst_pc  out  32  byte PC of head instruction
- fetch_err  out  1  sticky fetch error
- busy  out  1  a request is outstanding (state REQ, WAIT or DISCARD)

Function
REQ-007 FSM states SHALL be IDLE, REQ, WAIT, DISCARD, ERR.
REQ-008 In REQ, IM_enable=1, IM_read=1 and IM_addr=pc[addr_size+1:2] for exactly one cycle; next state WAIT; in all other states IM_enable=IM_read=0.
REQ-009 In WAIT, on IM_finish=1 with IM_resp=OKAY, {IM_out, pc} SHALL be pushed into the buffer, pc SHALL become pc+4 (mod 2^32), and the next state SHALL be REQ if space remains, else IDLE.
REQ-010 In WAIT, on IM_finish=1 with IM_resp!=OKAY, nothing SHALL be pushed, fetch_err SHALL be set, and the next state SHALL be ERR.
REQ-011 A wait counter SHALL count WAIT/DISCARD cycles; reaching TIMEOUT without IM_finish SHALL set fetch_err and enter ERR.
REQ-012 The buffer SHALL be a 2-entry FIFO of {instruction, pc}; a request SHALL be issued only when occupancy plus outstanding requests < 2, so overflow is impossible.
REQ-013 IDLE SHALL move to REQ in the cycle after space becomes available (pop at full buffer).
REQ-014 inst_valid=1 iff occupancy>0; a pop occurs when inst_valid and inst_ready are both 1; simultaneous push and pop SHALL keep occupancy unchanged.
REQ-015 redirect_valid SHALL flush the buffer, load pc=redirect_pc with bits [1:0] forced to 0, and clear fetch_err; the next state SHALL be DISCARD if in WAIT without IM_finish this cycle, else REQ.
REQ-016 A response arriving in the same cycle as redirect_valid SHALL be dropped.
REQ-017 redirect_valid SHALL take priority over a same-cycle pop and a same-cycle push.
REQ-018 DISCARD SHALL drop the next IM_finish (any resp), then go to REQ; its timeout SHALL also go to REQ without setting fetch_err.
REQ-019 ERR SHALL issue no requests and hold the buffer contents poppable; only redirect_valid or rst SHALL leave ERR.
REQ-020 The PC SHALL wrap from 32'hFFFF_FFFC to 32'h0 without error.

Reset
REQ-021 While rst=1 on a clock edge: state=IDLE, pc=BOOT_PC, buffer empty, wait counter=0, fetch_err=0, IM_enable=IM_read=IM_write=0, IM_in=0, inst_valid=0, inst_out=0, inst_pc=0, busy=0.
REQ-022 Reset mid-request SHALL abandon the outstanding request; a late IM_finish SHALL be ignored while in IDLE.
REQ-023 The first request SHALL be driven in the second cycle after rst deasserts (IDLE -> REQ -> drive).

Verification
REQ-024 Reset, OKAY memory with mem[0..3]=A,B,C,D, inst_ready=1 -> inst_out sequence A,B,C,D with inst_pc 0,4,8,12, one instruction every 2 cycles.
REQ-025 inst_ready=0 for 20 cycles -> exactly 2 requests issued, inst_valid=1 holding A at pc 0, IM_enable then 0 until a pop.
REQ-026 redirect_valid with redirect_pc=32'h40 during WAIT -> in-flight response dropped, buffer flushed, next IM_addr=10'h010, inst_pc=32'h40.
REQ-027 IM_resp=ERROR with IM_finish at pc 8 -> fetch_err=1, no push, no further IM_enable; redirect to 0 -> fetch_err=0, fetch resumes at 0.
REQ-028 Memory never asserts IM_finish -> fetch_err=1 exactly TIMEOUT=15 cycles after entering WAIT.
REQ-029 redirect_pc=32'hFFFF_FFFC -> fetches at 32'hFFFF_FFFC then 32'h0 (IM_addr 10'h3FF then 10'h000), fetch_err stays 0.

Source files
------------

// File: rtl/im_fetch_master.sv
// Instruction-memory fetch master. Prefetches sequential words into a 2-entry
// {instruction, pc} buffer and handles redirect/flush, bus errors and timeouts.

module im_fetch_master #(
    parameter int          data_size = 32,
    parameter int          addr_size = 10,
    parameter logic [31:0] BOOT_PC   = 32'h0,
    parameter int          TIMEOUT   = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 IM_enable,
    output logic                 IM_read,
    output logic                 IM_write,
    output logic [data_size-1:0] IM_in,
    output logic [addr_size-1:0] IM_addr,
    input  logic [data_size-1:0] IM_out,
    input  logic                 IM_ready,
    input  logic [1:0]           IM_resp,
    input  logic                 IM_finish,
    input  logic                 redirect_valid,
    input  logic [31:0]          redirect_pc,
    input  logic                 inst_ready,
    output logic                 inst_valid,
    output logic [data_size-1:0] inst_out,
    output logic [31:0]          inst_pc,
    output logic                 fetch_err,
    output logic                 busy
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, DISCARD, ERR} state_t;

    localparam int                wcnt_w    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [wcnt_w-1:0] wait_last = wcnt_w'(TIMEOUT - 1);
    localparam logic [1:0]        resp_okay = 2'b00;

    state_t                state, state_next;
    logic [31:0]           pc, pc_next;
    logic [wcnt_w-1:0]     wait_cnt, wait_next;
    logic                  err_next;

    logic [data_size-1:0]  buf_data [2];
    logic [31:0]           buf_pc   [2];
    logic                  rd_ptr, wr_ptr;
    logic [1:0]            count, count_after;
    logic                  push, pop;

    // IM_ready is informational and redirect targets are word aligned.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, IM_ready, redirect_pc[1:0]};

    // A redirect cancels both the pop and the push of the same cycle.
    assign push        = (state == WAIT) && IM_finish && (IM_resp == resp_okay) && !redirect_valid;
    assign pop         = inst_valid && inst_ready && !redirect_valid;
    assign count_after = count + {1'b0, push} - {1'b0, pop};

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned and infers a latch.
        state_next = state;
        pc_next    = pc;
        wait_next  = wait_cnt;
        err_next   = fetch_err;
        if (redirect_valid) begin
            pc_next    = {redirect_pc[31:2], 2'b00};
            err_next   = 1'b0;
            wait_next  = '0;
            state_next = (state == WAIT && !IM_finish) ? DISCARD : REQ;
        end else begin
            case (state)
                IDLE: begin
                    if (count < 2'd2)
                        state_next = REQ;
                end
                REQ: begin
                    wait_next  = '0;
                    state_next = WAIT;
                end
                WAIT: begin
                    if (IM_finish) begin
                        if (IM_resp == resp_okay) begin
                            pc_next    = pc + 32'd4;
                            state_next = (count_after < 2'd2) ? REQ : IDLE;
                        end else begin
                            err_next   = 1'b1;
                            state_next = ERR;
                        end
                    end else if (wait_cnt == wait_last) begin
                        err_next   = 1'b1;
                        state_next = ERR;
                    end else begin
                        wait_next = wait_cnt + 1'b1;
                    end
                end
                DISCARD: begin
                    if (IM_finish || wait_cnt == wait_last)
                        state_next = REQ;
                    else
                        wait_next = wait_cnt + 1'b1;
                end
                ERR:     state_next = ERR;
                default: state_next = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= BOOT_PC;
            wait_cnt  <= '0;
            fetch_err <= 1'b0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            count     <= 2'd0;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            wait_cnt  <= wait_next;
            fetch_err <= err_next;
            if (redirect_valid) begin
                rd_ptr <= 1'b0;
                wr_ptr <= 1'b0;
                count  <= 2'd0;
            end else begin
                if (push)
                    wr_ptr <= ~wr_ptr;
                if (pop)
                    rd_ptr <= ~rd_ptr;
                count <= count_after;
            end
        end
    end

    // NOTE: buffer storage is not reset; the outputs are gated by inst_valid instead.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_data[wr_ptr] <= IM_out;
            buf_pc[wr_ptr]   <= pc;
        end
    end

    assign IM_enable  = (state == REQ);
    assign IM_read    = (state == REQ);
    assign IM_write   = 1'b0;
    assign IM_in      = '0;
    assign IM_addr    = pc[addr_size+1:2];

    assign inst_valid = (count != 2'd0);
    assign inst_out   = inst_valid ? buf_data[rd_ptr] : '0;
    assign inst_pc    = inst_valid ? buf_pc[rd_ptr] : 32'h0;
    assign busy       = (state == REQ) || (state == WAIT) || (state == DISCARD);

endmodule

// File: tb/tb_im_fetch_master.sv
// Bench for im_fetch_master: cycle table for the boot stream, directed corner
// sequences, and a randomized run checked against an in-order PC/data scoreboard.

module tb_im_fetch_master;

    logic        clk;
    logic        rst;
    logic        IM_enable, IM_read, IM_write;
    logic [31:0] IM_in;
    logic [9:0]  IM_addr;
    logic [31:0] IM_out;
    logic        IM_ready;
    logic [1:0]  IM_resp;
    logic        IM_finish;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_ready;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        fetch_err;
    logic        busy;

    im_fetch_master dut (
        .clk            (clk),
        .rst            (rst),
        .IM_enable      (IM_enable),
        .IM_read        (IM_read),
        .IM_write       (IM_write),
        .IM_in          (IM_in),
        .IM_addr        (IM_addr),
        .IM_out         (IM_out),
        .IM_ready       (IM_ready),
        .IM_resp        (IM_resp),
        .IM_finish      (IM_finish),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_ready     (inst_ready),
        .inst_valid     (inst_valid),
        .inst_out       (inst_out),
        .inst_pc        (inst_pc),
        .fetch_err      (fetch_err),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    // memory model state
    bit         mem_pend;
    int         mem_cnt;
    logic [9:0] mem_addr;
    int         mem_lat;
    bit         mem_silent;
    bit         err_en;
    logic [9:0] err_addr;
    int         req_count;
    bit         redir_since_req;

    typedef struct {
        logic        ready;
        logic        en;
        logic [9:0]  addr;
        logic        valid;
        logic [31:0] out;
        logic [31:0] pc;
    } vec_t;

    vec_t vecs [10];

    function automatic logic [31:0] mem_word(input logic [9:0] a);
        return 32'h1357_9BDF ^ {a, 22'h0} ^ {22'h0, a} ^ {11'h0, a, 11'h0};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // One clock: outputs are sampled and inputs driven on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        IM_finish = 1'b0;
        IM_resp   = 2'b00;
        IM_out    = $urandom;
        if (mem_pend) begin
            mem_cnt--;
            if (mem_cnt <= 0) begin
                mem_pend = 1'b0;
                if (!mem_silent) begin
                    IM_finish = 1'b1;
                    IM_resp   = (err_en && mem_addr == err_addr) ? 2'b01 : 2'b00;
                    IM_out    = mem_word(mem_addr);
                end
            end
        end
        if (IM_enable === 1'b1) begin
            mem_pend        = 1'b1;
            mem_addr        = IM_addr;
            mem_cnt         = mem_lat;
            req_count++;
            redir_since_req = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;
        mem_pend       = 1'b0;
        mem_silent     = 1'b0;
        err_en         = 1'b0;
        mem_lat        = 1;
        IM_finish      = 1'b0;
        tick();
        tick();
        rst             = 1'b0;
        req_count       = 0;
        redir_since_req = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          pops;
        int          n;
        logic [31:0] exp_pc;

        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b0;
        IM_out = 32'h0; IM_ready = 1'b1; IM_resp = 2'b00; IM_finish = 1'b0;
        mem_pend = 1'b0; mem_cnt = 0; mem_addr = '0; mem_lat = 1; mem_silent = 1'b0;
        err_en = 1'b0; err_addr = '0; req_count = 0; redir_since_req = 1'b0;

        for (int i = 0; i < 10; i++) begin
            int k;
            k = i / 2;
            vecs[i].ready = 1'b1;
            vecs[i].en    = (i % 2 == 0);
            vecs[i].addr  = 10'(k);
            vecs[i].valid = (i % 2 == 0) && (i > 0);
            vecs[i].out   = (k > 0) ? mem_word(10'(k - 1)) : 32'h0;
            vecs[i].pc    = (k > 0) ? 32'((k - 1) * 4) : 32'h0;
        end

        // reset state
        tick();
        tick();
        check("rst_enable", IM_enable, 0);
        check("rst_read", IM_read, 0);
        check("rst_write", IM_write, 0);
        check("rst_in", IM_in, 0);
        check("rst_valid", inst_valid, 0);
        check("rst_out", inst_out, 0);
        check("rst_pc", inst_pc, 0);
        check("rst_err", fetch_err, 0);
        check("rst_busy", busy, 0);

        // boot stream A,B,C,D, one instruction every two cycles
        do_reset();
        inst_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            inst_ready = vecs[i].ready;
            check($sformatf("vec%0d_en", i), IM_enable, vecs[i].en);
            check($sformatf("vec%0d_rd", i), IM_read, vecs[i].en);
            if (vecs[i].en)
                check($sformatf("vec%0d_addr", i), IM_addr, vecs[i].addr);
            check($sformatf("vec%0d_valid", i), inst_valid, vecs[i].valid);
            if (vecs[i].valid) begin
                check($sformatf("vec%0d_out", i), inst_out, vecs[i].out);
                check($sformatf("vec%0d_pc", i), inst_pc, vecs[i].pc);
            end
        end

        // stalled consumer: exactly two requests, then idle until a pop
        do_reset();
        repeat (20) tick();
        check("stall_reqs", req_count, 2);
        check("stall_valid", inst_valid, 1);
        check("stall_out", inst_out, mem_word(10'd0));
        check("stall_pc", inst_pc, 32'h0);
        check("stall_en", IM_enable, 0);
        check("stall_busy", busy, 0);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        check("pop_en_same", IM_enable, 0);
        check("pop_head_pc", inst_pc, 32'h4);
        tick();
        check("pop_en_next", IM_enable, 1);
        check("pop_addr_next", IM_addr, 10'd2);

        // redirect while waiting: flush and drop the in-flight response
        do_reset();
        tick();
        mem_lat = 3;
        tick();
        tick();
        tick();
        check("redir_pre_valid", inst_valid, 1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick();
        redirect_valid = 1'b0;
        check("redir_flush", inst_valid, 0);
        check("redir_busy", busy, 1);
        check("redir_en0", IM_enable, 0);
        tick();
        check("redir_discard_en", IM_enable, 0);
        mem_lat = 1;
        tick();
        check("redir_en", IM_enable, 1);
        check("redir_addr", IM_addr, 10'h010);
        check("redir_drop", inst_valid, 0);
        tick();
        tick();
        check("redir_valid", inst_valid, 1);
        check("redir_pc", inst_pc, 32'h40);
        check("redir_out", inst_out, mem_word(10'h010));

        // reset mid-request; late response ignored in IDLE
        do_reset();
        inst_ready = 1'b1;
        tick();
        check("rstmid_en", IM_enable, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstmid_busy", busy, 0);
        check("rstmid_valid", inst_valid, 0);
        tick();
        check("rstmid_en2", IM_enable, 1);
        check("rstmid_addr", IM_addr, 10'd0);
        check("rstmid_nopush", inst_valid, 0);
        tick();
        tick();
        check("rstmid_pc", inst_pc, 32'h0);
        check("rstmid_out", inst_out, mem_word(10'd0));

        // error response at pc 8, then recovery by redirect
        do_reset();
        inst_ready = 1'b1;
        err_en     = 1'b1;
        err_addr   = 10'd2;
        pops = 0;
        n    = 0;
        while (fetch_err !== 1'b1 && n < 40) begin
            tick();
            n++;
            if (fetch_err !== 1'b1 && inst_valid && inst_ready)
                pops++;
        end
        check("err_set", fetch_err, 1);
        check("err_reqs", req_count, 3);
        check("err_pops", pops, 2);
        check("err_nopush", inst_valid, 0);
        req_count = 0;
        repeat (5) tick();
        check("err_no_req", req_count, 0);
        check("err_hold", fetch_err, 1);
        check("err_busy", busy, 0);
        err_en         = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        tick();
        redirect_valid = 1'b0;
        check("err_clear", fetch_err, 0);
        check("err_resume_en", IM_enable, 1);
        check("err_resume_addr", IM_addr, 10'd0);
        tick();
        tick();
        check("err_resume_pc", inst_pc, 32'h0);
        check("err_resume_out", inst_out, mem_word(10'd0));

        // silent memory: timeout after exactly 15 wait cycles
        do_reset();
        mem_silent = 1'b1;
        tick();
        check("to_req", IM_enable, 1);
        repeat (15) tick();
        check("to_err_before", fetch_err, 0);
        check("to_busy_before", busy, 1);
        tick();
        check("to_err_at", fetch_err, 1);
        check("to_busy_at", busy, 0);
        check("to_en", IM_enable, 0);
        mem_silent = 1'b0;

        // PC wrap from FFFF_FFFC to 0
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        inst_ready     = 1'b1;
        check("wrap_en", IM_enable, 1);
        check("wrap_addr_hi", IM_addr, 10'h3FF);
        tick();
        tick();
        check("wrap_pc_hi", inst_pc, 32'hFFFF_FFFC);
        check("wrap_out_hi", inst_out, mem_word(10'h3FF));
        check("wrap_addr_lo", IM_addr, 10'h000);
        tick();
        tick();
        check("wrap_pc_lo", inst_pc, 32'h0);
        check("wrap_out_lo", inst_out, mem_word(10'h000));
        check("wrap_err", fetch_err, 0);

        // randomized run against an in-order stream scoreboard
        do_reset();
        exp_pc = 32'h0;
        pops   = 0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            redirect_valid = 1'b0;
            inst_ready     = ($urandom_range(0, 3) != 0);
            mem_lat        = $urandom_range(1, 4);
            if (IM_enable !== 1'b1 && !(mem_pend && redir_since_req) && $urandom_range(0, 24) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                             : 32'($urandom);
                if (mem_pend)
                    redir_since_req = 1'b1;
                exp_pc = redirect_pc & 32'hFFFF_FFFC;
            end else if (inst_valid && inst_ready) begin
                check("rand_pc", inst_pc, exp_pc);
                check("rand_out", inst_out, mem_word(exp_pc[11:2]));
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
        end
        redirect_valid = 1'b0;
        check("rand_progress", (pops > 100), 1);
        check("rand_no_err", fetch_err, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
